apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
//  APB requester (bridge master) that drives the slave-side memories on the APB bus.
//  Converts a valid/ready command port into APB SETUP/ACCESS transfers on a single PSEL.
//  Returns read data, slave error and timeout status on a 1-cycle response pulse.
//  Sits between the testbench/CPU-side command source and apb_mem-class slaves.
// PARAMETERS
//  ADDR_W   32  width of cmd_addr/_PADDR
//  DATA_W   32  width of write/read data
//  TIMEOUT  16  max ACCESS cycles waiting for _PREADY before abort (>=1)
// PORTS
//  _PCLK        in   1       clock; all logic on rising edge
//  _PRESET      in   1       asynchronous, active-high reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       command accepted when valid&&ready at a rising edge
//  cmd_write    in   1       1=write, 0=read
//  cmd_addr     in   ADDR_W  transfer address
//  cmd_wdata    in   DATA_W  write data (ignored for reads)
//  rsp_valid    out  1       1-cycle pulse: transfer finished; no backpressure
//  rsp_rdata    out  DATA_W  read data (0 for writes, timeouts and slave errors)
//  rsp_err      out  1       _PSLVERR seen, or timeout
//  rsp_timeout  out  1       transfer aborted by timeout
//  _PSEL1       out  1       APB select
//  _PENABLE     out  1       APB enable (ACCESS phase)
//  _PWRITE      out  1       APB direction
//  _PADDR       out  ADDR_W  APB address
//  _PWDATA      out  DATA_W  APB write data
//  _PRDATA      in   DATA_W  APB read data
//  _PREADY      in   1       APB ready
//  _PSLVERR     in   1       APB slave error; sampled only with _PREADY in ACCESS
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; wait counter 0. Asserting reset mid-transfer drops
//   _PSEL1/_PENABLE immediately; no rsp_valid is issued for the killed transfer.
//  FSM (registered): IDLE, SETUP, ACCESS.
//   IDLE:   cmd_ready=1. On cmd_valid, latch write/addr/wdata onto _PWRITE/_PADDR/_PWDATA
//           -> SETUP.
//   SETUP:  _PSEL1=1, _PENABLE=0, cmd_ready=0 -> ACCESS unconditionally.
//   ACCESS: _PSEL1=1, _PENABLE=1. Wait counter increments on each edge with _PREADY=0.
//    _PREADY=1: complete. Capture _PRDATA (reads, no error) and _PSLVERR.
//     cmd_ready=1 this cycle: with cmd_valid, latch the new cmd -> SETUP (back-to-back,
//     _PSEL1 stays high); else -> IDLE.
//    _PREADY=0 and counter==TIMEOUT-1: abort -> IDLE; rsp_err=rsp_timeout=1.
//  cmd_ready is 0 in SETUP and in ACCESS while _PREADY=0.
//  _PADDR/_PWDATA/_PWRITE are stable from SETUP through the completing ACCESS edge,
//   then hold their value until the next command is latched.
//  Response: registered; rsp_valid is high for exactly the cycle after the completing or
//   aborting edge. rsp_* fields are valid only with rsp_valid, and are 0 otherwise.
//  Latency, zero-wait slave: accept edge N, SETUP cycle N+1, ACCESS cycle N+2,
//   complete at edge N+3, rsp_valid in cycle N+3. Each slave wait cycle adds 1.
//  Wait counter: $clog2(TIMEOUT+1) bits; cleared on entry to SETUP; never wraps.
//  _PREADY/_PSLVERR are ignored outside ACCESS. X on _PRDATA during a read passes
//   through unchanged; this block does not check it.
// STRUCTURE
//  Package apb_pkg: typedef enum logic [1:0] {APB_IDLE=0, APB_SETUP=1, APB_ACCESS=2}
//   apb_state_e, shared with slave models; APB_TIMEOUT_DEFAULT=16.
//  One sub-module: apb_wait_timer (clear, count-enable, expired output), sized by TIMEOUT.
//  Everything else is flat: FSM, command latch, response register.
// TESTING
//  1 Write 0x3 <= 0xDEADBEEF, slave 0 wait -> _PSEL1 2 cycles, _PENABLE 1 cycle;
//    rsp_valid 3 cycles after accept; rsp_err=0.
//  2 Read 0x3 after test 1, slave 3 waits -> rsp_rdata=0xDEADBEEF, rsp_valid 6 cycles
//    after accept; _PADDR stable throughout.
//  3 Read 0x20 against DEPTH=5 slave (_PSLVERR=1) -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
//  4 _PREADY held 0, TIMEOUT=16 -> 16 ACCESS cycles, then _PSEL1=0;
//    rsp_err=rsp_timeout=1; next cmd is accepted in IDLE.
//  5 Two cmds back-to-back (cmd_valid held) -> ACCESS->SETUP with no IDLE gap;
//    _PSEL1 high continuously; two rsp_valid pulses 2 cycles apart.
//  6 Reset asserted in ACCESS -> _PSEL1/_PENABLE=0 before the next edge; no rsp_valid;
//    normal operation resumes after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions for the bridge master and the slave models.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on PREADY; flags the last allowed wait cycle.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic _PCLK,
  input  logic _PRESET,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Saturates at TIMEOUT so a stalled count can never wrap back into range.
  always_ff @(posedge _PCLK or posedge _PRESET) begin
    if (_PRESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count < CW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command into SETUP/ACCESS transfers and
// reports each completion or timeout abort on a one-cycle response pulse.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = APB_TIMEOUT_DEFAULT
) (
  input  logic              _PCLK,
  input  logic              _PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              _PSEL1,
  output logic              _PENABLE,
  output logic              _PWRITE,
  output logic [ADDR_W-1:0] _PADDR,
  output logic [DATA_W-1:0] _PWDATA,
  input  logic [DATA_W-1:0] _PRDATA,
  input  logic              _PREADY,
  input  logic              _PSLVERR
);

  apb_state_e state;
  logic       load_cmd;
  logic       wait_en;
  logic       expired;

  // Ready is offered in the completing ACCESS cycle too, so commands chain without an IDLE gap.
  assign cmd_ready = !_PRESET &&
                     ((state == APB_IDLE) || ((state == APB_ACCESS) && _PREADY));
  assign load_cmd  = cmd_valid && cmd_ready;
  assign wait_en   = (state == APB_ACCESS) && !_PREADY;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    ._PCLK   (_PCLK),
    ._PRESET (_PRESET),
    .clear   (load_cmd),
    .en      (wait_en),
    .expired (expired)
  );

  always_ff @(posedge _PCLK or posedge _PRESET) begin
    if (_PRESET) begin
      state       <= APB_IDLE;
      _PSEL1      <= 1'b0;
      _PENABLE    <= 1'b0;
      _PWRITE     <= 1'b0;
      _PADDR      <= '0;
      _PWDATA     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;

      if (load_cmd) begin
        _PWRITE <= cmd_write;
        _PADDR  <= cmd_addr;
        _PWDATA <= cmd_wdata;
      end

      case (state)
        APB_IDLE: begin
          if (load_cmd) begin
            state    <= APB_SETUP;
            _PSEL1   <= 1'b1;
            _PENABLE <= 1'b0;
          end
        end

        APB_SETUP: begin
          state    <= APB_ACCESS;
          _PENABLE <= 1'b1;
        end

        APB_ACCESS: begin
          if (_PREADY) begin
            rsp_valid <= 1'b1;
            rsp_err   <= _PSLVERR;
            if (!_PWRITE && !_PSLVERR) begin
              rsp_rdata <= _PRDATA;
            end
            _PENABLE <= 1'b0;
            if (load_cmd) begin
              state <= APB_SETUP;
            end else begin
              state  <= APB_IDLE;
              _PSEL1 <= 1'b0;
            end
          end else if (expired) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= APB_IDLE;
            _PSEL1      <= 1'b0;
            _PENABLE    <= 1'b0;
          end
        end

        default: begin
          state    <= APB_IDLE;
          _PSEL1   <= 1'b0;
          _PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule
